// File: rtl/float_mult_arbiter.sv
// rtl/float_mult_arbiter.sv - round-robin packet-locked sharing of one float_mult; FLOAT_ARB_STATS_EN adds issue/stall counters
module float_mult_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [1:0]                      mult_valid,
  input  logic [1:0]                      mult_ready,
  output logic [2*DATA_WIDTH-1:0]         mult_data,
  output logic                            mult_last,
  input  logic                            res_valid,
  output logic                            res_ready,
  input  logic [DATA_WIDTH-1:0]           res_data,
  input  logic                            res_last,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_last,
  output logic                            busy,
  output logic                            err_orphan
`ifdef FLOAT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]           stat_issued,
  output logic [15:0]                     stat_stall
`endif
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam logic [CW-1:0] TAG_FULL = CW'(TAG_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state;
  logic [IW-1:0]           grant;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           pick, pick_hi, pick_lo;
  logic                    found_hi, found_lo, pick_found;
  logic [IW-1:0]           tag_mem [TAG_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           tag_cnt;
  logic [IW-1:0]           head;
  logic                    tag_empty, tag_room, both_ready, locked;
  logic                    offer, issue, head_ready, pop;
  logic                    sel_valid, sel_last;
  logic [2*DATA_WIDTH-1:0] sel_data;

  // Next requester in cyclic order starting at rr_ptr; falls back to lowest index on wrap
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IW'(i) >= rr_ptr)) begin
        pick_hi  = IW'(i);
        found_hi = 1'b1;
      end
      if (req_valid[i]) begin
        pick_lo  = IW'(i);
        found_lo = 1'b1;
      end
    end
    pick       = found_hi ? pick_hi : pick_lo;
    pick_found = found_hi | found_lo;
  end

  // Select the granted requester's operands and the tag-FIFO head consumer's ready
  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    head_ready = 1'b0;
    head       = tag_mem[rd_ptr];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*2*DATA_WIDTH +: 2*DATA_WIDTH];
      end
      if (head == IW'(i)) begin
        head_ready = rsp_ready[i];
      end
    end
  end

  // Handshake terms and output steering; result side is forced quiet while reset is held
  always_comb begin
    locked     = (state == LOCKED);
    tag_empty  = (tag_cnt == '0);
    tag_room   = (tag_cnt != TAG_FULL);
    both_ready = mult_ready[0] & mult_ready[1];
    offer      = locked & sel_valid & tag_room;
    issue      = offer & both_ready;
    mult_valid = {2{offer}};
    mult_data  = locked ? sel_data : '0;
    mult_last  = locked & sel_last;
    req_ready  = '0;
    rsp_valid  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IW'(i)) begin
        req_ready[i] = locked & both_ready & tag_room;
      end
      if (head == IW'(i)) begin
        rsp_valid[i] = aresetn & ~tag_empty & res_valid;
      end
    end
    res_ready = aresetn & (tag_empty | head_ready);
    pop       = res_valid & res_ready & ~tag_empty;
    rsp_data  = aresetn ? res_data : '0;
    rsp_last  = aresetn & res_last;
    busy      = locked | ~tag_empty;
  end

  // Grant FSM: lock onto one requester until its last beat issues, then advance rr_ptr
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (issue && sel_last) begin
            state  <= IDLE;
            rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag storage: records which requester owns each beat in flight
  always_ff @(posedge aclk) begin
    if (issue) begin
      tag_mem[wr_ptr] <= grant;
    end
  end

  // Tag FIFO pointers and occupancy; TAG_DEPTH is a power of two so pointers wrap freely
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (issue && !pop)      tag_cnt <= tag_cnt + 1'b1;
      else if (pop && !issue) tag_cnt <= tag_cnt - 1'b1;
    end
  end

  // Sticky flag for a result that arrives with no owner recorded
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_orphan <= 1'b0;
    end else if (res_valid && tag_empty) begin
      err_orphan <= 1'b1;
    end
  end

`ifdef FLOAT_ARB_STATS_EN
  logic [15:0] issued_cnt [NUM_REQ];

  // Saturating per-requester issue counters and multiplier back-pressure counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REQ; i++) issued_cnt[i] <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && (grant == IW'(i)) && (issued_cnt[i] != 16'hFFFF)) begin
          issued_cnt[i] <= issued_cnt[i] + 16'd1;
        end
      end
      if (offer && !both_ready && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end

  // Flatten the counters onto the stats bus
  always_comb begin
    stat_issued = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_issued[i*16 +: 16] = issued_cnt[i];
  end
`endif

endmodule

// File: tb/tb_float_mult_arbiter.sv
// tb/tb_float_mult_arbiter.sv - scoreboard bench for float_mult_arbiter with a latency-6 multiplier model
module tb_float_mult_arbiter;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int TD  = 8;
  localparam int LAT = 6;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [N-1:0]      req_valid, req_ready, req_last;
  logic [N*2*DW-1:0] req_data;
  logic [1:0]        mult_valid, mult_ready;
  logic [2*DW-1:0]   mult_data;
  logic              mult_last;
  logic              res_valid, res_ready, res_last;
  logic [DW-1:0]     res_data;
  logic [N-1:0]      rsp_valid, rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              rsp_last, busy, err_orphan;
`ifdef FLOAT_ARB_STATS_EN
  logic [N*16-1:0]   stat_issued;
  logic [15:0]       stat_stall;
`endif

  float_mult_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .mult_valid(mult_valid), .mult_ready(mult_ready), .mult_data(mult_data), .mult_last(mult_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .err_orphan(err_orphan)
`ifdef FLOAT_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct { logic [31:0] a; logic [31:0] b; int unsigned p; logic last; } beat_t;
  typedef struct { int r; logic [31:0] d; logic last; } exp_t;
  typedef struct { logic [31:0] d; logic last; int due; } mres_t;
  typedef struct { int c; int r; } iss_t;

  beat_t pq [N][$];
  beat_t mdl [N][$];
  exp_t  exp_q[$];
  mres_t mq[$];
  iss_t  issue_log[$];
  int    rsp_log[$];

  int   checks = 0;
  int   failures = 0;
  int   m_rr = 0;
  bit   mr_rand = 0, rsp_rand = 0, orphan_req = 0, orphan_now = 0;
  logic [N-1:0] rsp_force = '1;
  int   extra_max = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] itof(input int unsigned v);
    int msb;
    logic [31:0] m;
    msb = 0;
    for (int i = 0; i < 32; i++) if (v[i]) msb = i;
    m = v << (23 - msb);
    return {1'b0, 8'(127 + msb), m[22:0]};
  endfunction

  // Exact single-precision multiply for operands whose product fits 24 significant bits
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [9:0]  e;
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = {2'b0, x[30:23]} + {2'b0, y[30:23]} - 10'd127;
    if (p[47]) return {1'b0, e[7:0] + 8'd1, p[46:24]};
    return {1'b0, e[7:0], p[45:23]};
  endfunction

  task automatic post_pkt(input int r, input int len, input int a0, input int bfix);
    for (int k = 0; k < len; k++) begin
      beat_t bt;
      int unsigned ia, ib;
      ia = (a0 > 0) ? a0 + k : $urandom_range(1, 1000);
      ib = (a0 > 0) ? bfix : $urandom_range(1, 1000);
      bt.a = itof(ia);
      bt.b = itof(ib);
      bt.p = ia * ib;
      bt.last = (k == len - 1);
      pq[r].push_back(bt);
      mdl[r].push_back(bt);
    end
  endtask

  // Reference: whole packets served round-robin from m_rr among requesters with posted work
  task automatic commit();
    beat_t bt;
    int pick;
    forever begin
      pick = -1;
      for (int k = 0; k < N && pick < 0; k++) begin
        if (mdl[(m_rr + k) % N].size() > 0) pick = (m_rr + k) % N;
      end
      if (pick < 0) break;
      do begin
        bt = mdl[pick].pop_front();
        exp_q.push_back('{pick, itof(bt.p), bt.last});
      end while (!bt.last);
      m_rr = (pick + 1) % N;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    bit pend;
    pend = 1;
    while (pend && n < 3000) begin
      @(negedge aclk);
      n++;
      pend = (exp_q.size() > 0);
      for (int r = 0; r < N; r++) if (pq[r].size() > 0) pend = 1;
    end
    chk(exp_q.size() == 0, name, exp_q.size(), 0);
  endtask

  // Producers: present each requester's queued beats, retire them on handshake
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge aclk);
      for (int r = 0; r < N; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          issue_log.push_back('{cyc, r});
          void'(pq[r].pop_front());
        end
      end
      @(posedge aclk);
      #1;
      for (int r = 0; r < N; r++) begin
        if (pq[r].size() > 0) begin
          req_valid[r] = 1'b1;
          req_last[r]  = pq[r][0].last;
          req_data[r*2*DW +: 2*DW] = {pq[r][0].b, pq[r][0].a};
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
        end
      end
    end
  end

  // Multiplier model (fixed latency plus optional jitter) and consumer ready drivers
  initial begin
    int due;
    mult_ready = '0;
    res_valid  = 1'b0;
    res_data   = '0;
    res_last   = 1'b0;
    rsp_ready  = '0;
    forever begin
      @(negedge aclk);
      if (mult_valid[0] && mult_ready == 2'b11) begin
        due = cyc + LAT + int'($urandom_range(0, extra_max));
        if (mq.size() > 0 && due < mq[$].due) due = mq[$].due;
        mq.push_back('{fmul(mult_data[31:0], mult_data[63:32]), mult_last, due});
      end
      if (res_valid && res_ready && !orphan_now && mq.size() > 0) void'(mq.pop_front());
      @(posedge aclk);
      #1;
      mult_ready = mr_rand ? {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)} : 2'b11;
      for (int i = 0; i < N; i++) rsp_ready[i] = rsp_rand ? ($urandom_range(0, 2) != 0) : rsp_force[i];
      orphan_now = orphan_req;
      if (orphan_now) begin
        res_valid = 1'b1;
        res_data  = 32'h7F7F_0001;
        res_last  = 1'b1;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        res_valid = 1'b1;
        res_data  = mq[0].d;
        res_last  = mq[0].last;
      end else begin
        res_valid = 1'b0;
        res_data  = '0;
        res_last  = 1'b0;
      end
    end
  end

  // Monitor: pop the scoreboard on every consumer handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (mult_valid != 2'b00) chk(mult_valid == 2'b11, "mult_valid_pair", mult_valid, 3);
        if (rsp_valid != '0) chk($onehot(rsp_valid), "rsp_onehot", rsp_valid, 0);
        for (int i = 0; i < N; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            rsp_log.push_back(cyc);
            if (exp_q.size() == 0) begin
              chk(1'b0, "rsp_unexpected", i, 0);
            end else begin
              e = exp_q.pop_front();
              chk(i == e.r, "rsp_consumer", i, e.r);
              chk(rsp_data == e.d, "rsp_data", rsp_data, e.d);
              chk(rsp_last == e.last, "rsp_last", rsp_last, e.last);
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge aclk);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, n;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk({mult_valid, req_ready, rsp_valid, res_ready, busy, err_orphan, rsp_last, mult_last} == '0,
        "reset_outputs", {mult_valid, req_ready, rsp_valid, res_ready, busy, err_orphan}, 0);
    chk(mult_data == '0 && rsp_data == '0, "reset_data", mult_data, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk(busy == 1'b0, "idle_busy", busy, 0);
    chk(err_orphan == 1'b0, "idle_err_orphan", err_orphan, 0);

    // Two concurrent 3-beat packets: requester 0 at t0+1..3, requester 1 at t0+5..7
    issue_log.delete();
    t0 = cyc + 1;
    post_pkt(0, 3, 0, 0);
    post_pkt(1, 3, 0, 0);
    commit();
    wait_drain("rr_drain");
    chk(issue_log.size() == 6, "rr_issue_count", issue_log.size(), 6);
    for (int k = 0; k < 6 && k < issue_log.size(); k++) begin
      chk(issue_log[k].c == t0 + ((k < 3) ? k + 1 : k + 2), "rr_issue_cycle", issue_log[k].c - t0,
          (k < 3) ? k + 1 : k + 2);
      chk(issue_log[k].r == ((k < 3) ? 0 : 1), "rr_issue_req", issue_log[k].r, (k < 3) ? 0 : 1);
    end

    // 4-beat packet a=1..4, b=2 -> 2,4,6,8 to consumer 0 with fixed multiplier latency
    issue_log.delete();
    rsp_log.delete();
    post_pkt(0, 4, 1, 2);
    commit();
    wait_drain("pkt4_drain");
    chk(issue_log.size() == 4, "pkt4_issue_count", issue_log.size(), 4);
    if (issue_log.size() > 0 && rsp_log.size() > 0)
      chk(rsp_log[0] - issue_log[0].c == LAT, "pkt4_latency", rsp_log[0] - issue_log[0].c, LAT);
    else
      chk(1'b0, "pkt4_latency_missing", rsp_log.size(), 1);

    // Tag FIFO full: consumers stalled, exactly TD beats go out
    issue_log.delete();
    rsp_force = '0;
    post_pkt(0, 12, 0, 0);
    commit();
    repeat (30) @(negedge aclk);
    chk(issue_log.size() == TD, "full_issue_count", issue_log.size(), TD);
    chk(mult_valid == 2'b00, "full_mult_valid", mult_valid, 0);
    chk(busy == 1'b1, "full_busy", busy, 1);
    rsp_force = '1;
    wait_drain("full_drain");
    chk(issue_log.size() == 12, "full_resume_count", issue_log.size(), 12);

    // Head-of-line: consumer 1 owns the head and stalls; consumer 0 must wait behind it
    rsp_force = 2'b01;
    post_pkt(1, 1, 0, 0);
    commit();
    n = 0;
    while (pq[1].size() > 0 && n < 100) begin @(negedge aclk); n++; end
    post_pkt(0, 1, 0, 0);
    commit();
    n = 0;
    while (!res_valid && n < 100) begin @(negedge aclk); n++; end
    chk(res_valid == 1'b1, "hol_res_valid", res_valid, 1);
    chk(res_ready == 1'b0, "hol_res_ready", res_ready, 0);
    chk(rsp_valid == 2'b10, "hol_rsp_valid", rsp_valid, 2);
    repeat (20) @(negedge aclk);
    chk(exp_q.size() == 2, "hol_blocked", exp_q.size(), 2);
    rsp_force = '1;
    wait_drain("hol_drain");

    // Orphan result with an empty tag FIFO
    chk(err_orphan == 1'b0, "pre_orphan_flag", err_orphan, 0);
    orphan_req = 1'b1;
    @(negedge aclk);
    orphan_req = 1'b0;
    chk(res_valid == 1'b1 && res_ready == 1'b1, "orphan_res_ready", {res_valid, res_ready}, 3);
    chk(rsp_valid == '0, "orphan_rsp_valid", rsp_valid, 0);
    repeat (100) @(negedge aclk);
    chk(err_orphan == 1'b1, "orphan_sticky", err_orphan, 1);

    // Reset mid-packet with beats outstanding
    issue_log.delete();
    rsp_force = '0;
    post_pkt(1, 6, 0, 0);
    commit();
    n = 0;
    while (issue_log.size() < 2 && n < 100) begin @(negedge aclk); n++; end
    chk(issue_log.size() >= 2, "rst_pre_issue", issue_log.size(), 2);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    for (int r = 0; r < N; r++) begin pq[r].delete(); mdl[r].delete(); end
    mq.delete();
    exp_q.delete();
    #1;
    chk({mult_valid, req_ready, rsp_valid, res_ready, busy, err_orphan} == '0, "rst_outputs",
        {mult_valid, req_ready, rsp_valid, res_ready, busy, err_orphan}, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    m_rr = 0;
    rsp_force = '1;
    @(negedge aclk);
    chk(busy == 1'b0, "rst_tag_cnt_clear", busy, 0);
    issue_log.delete();
    post_pkt(0, 2, 0, 0);
    post_pkt(1, 2, 0, 0);
    commit();
    wait_drain("rst_drain");
    chk(issue_log.size() > 0 && issue_log[0].r == 0, "rst_first_req",
        (issue_log.size() > 0) ? issue_log[0].r : -1, 0);

    // Randomized traffic with multiplier and consumer back-pressure
    mr_rand = 1;
    rsp_rand = 1;
    extra_max = 3;
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < N; r++) begin
        int np;
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) post_pkt(r, $urandom_range(1, 5), 0, 0);
      end
      commit();
      wait_drain("rand_drain");
    end
    chk(err_orphan == 1'b0, "rand_no_orphan", err_orphan, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_mult_arbiter.md
# float_mult_arbiter

Shares the single pipelined `float_mult` instance between `NUM_REQ` operand-pair producers, for example several `conv_input`-style window streamers. Arbitration is round-robin and packet-locked. Each issued beat's requester index is held in a tag FIFO so that results from the multiplier return to the correct consumer in issue order. The block sits between the producers/consumers and the `float_mult` AXI-Stream ports, all on the float clock domain.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requester/consumer pairs (2..8).
- `DATA_WIDTH`, 32: single-precision operand/result width.
- `TAG_DEPTH`, 16: maximum outstanding beats inside the multiplier; power of two.

Ports:
- `aclk` in 1: float clock; the only clock.
- `aresetn` in 1: reset, asynchronous assert, active-low.
- `req_valid` in `NUM_REQ`: per-requester operand valid.
- `req_ready` out `NUM_REQ`: per-requester operand accept.
- `req_data` in `NUM_REQ*2*DATA_WIDTH`: slice i is `{b,a}` for requester i.
- `req_last` in `NUM_REQ`: last beat of requester's packet.
- `mult_valid` out 2: to `s_axis_a/b_tvalid`; both bits always equal.
- `mult_ready` in 2: from `s_axis_a/b_tready`.
- `mult_data` out `2*DATA_WIDTH`: `{b,a}` to multiplier.
- `mult_last` out 1: to both `s_axis_*_tlast`.
- `res_valid` in 1: `m_axis_result_tvalid`.
- `res_ready` out 1: `m_axis_result_tready`.
- `res_data` in `DATA_WIDTH`: product.
- `res_last` in 1: product last.
- `rsp_valid` out `NUM_REQ`: one-hot result valid to consumer i.
- `rsp_ready` in `NUM_REQ`: consumer ready.
- `rsp_data` out `DATA_WIDTH`: shared result bus.
- `rsp_last` out 1: shared result last.
- `busy` out 1: grant held or tag FIFO non-empty.
- `err_orphan` out 1: sticky; a result arrived with the tag FIFO empty.

## Operation
- Grant FSM has two states:
  - IDLE: if any `req_valid`, pick the first valid index at or after `rr_ptr` (cyclic); register it in `grant` and go to LOCKED. No transfer happens in IDLE.
  - LOCKED: the granted requester is muxed to the mult port.
  - Issue condition: `issue = req_valid[grant] & mult_ready[0] & mult_ready[1] & (tag_cnt < TAG_DEPTH)`.
  - `mult_valid = {2{req_valid[grant] & tag_cnt<TAG_DEPTH}}`; `req_ready[grant] = issue`-gating terms excluding its own valid; all other `req_ready` are 0.
  - On an issue with `req_last=1`: go to IDLE and set `rr_ptr = grant+1` modulo `NUM_REQ`.
- Tag FIFO:
  - Each issue pushes `grant`.
  - Each result handshake (`res_valid & res_ready`) pops the head.
  - `tag_cnt` is `$clog2(TAG_DEPTH)+1` bits. Push and pop in the same cycle leave it unchanged.
  - Full blocks issue; there is no same-cycle bypass.
- Result routing:
  - FIFO non-empty: `rsp_valid[head] = res_valid`, `res_ready = rsp_ready[head]`.
  - `rsp_data`/`rsp_last` pass straight through.
  - Strict in-order: a stalled head consumer blocks all results (head-of-line blocking).
- Orphan result:
  - FIFO empty and `res_valid`: `res_ready=1` and the beat is dropped; all `rsp_valid` stay 0 and `err_orphan` is set.
  - `err_orphan` clears only on reset.

## Timing
- All outputs are 0 in reset. `grant=0`, `rr_ptr=0`, `tag_cnt=0`, FSM is in IDLE.
- Packet start: `req_valid` seen in IDLE at cycle t; the first beat can transfer at t+1. Back-to-back beats then run 1 per cycle.
- Mult-side and result-side paths are combinational (0 cycles). Only the FSM, `rr_ptr`, the tag FIFO and `err_orphan` are registered.
- `req_valid` dropping mid-packet keeps the grant; there is no timeout.
- Reset asserted mid-packet discards the grant and all outstanding tags. Results still in flight after reset count as orphans; the integrator resets `float_mult` alongside.
- `mult_ready` bits differing in a cycle means no issue.

## Configuration
- `FLOAT_ARB_STATS_EN` defined:
  - Adds output `stat_issued` (`NUM_REQ*16` bits): per-requester issued-beat counters that saturate at 0xFFFF and reset to 0.
  - Adds output `stat_stall` (16 bits): saturating count of cycles with `mult_valid=1` and the issue blocked by `mult_ready`.
- Undefined: these ports and their counters are absent. Behaviour is otherwise identical.

## Test plan
- Requester 0 sends a 4-beat packet (a=1.0,2.0,3.0,4.0; b=2.0) into a latency-6 multiplier model → `rsp_valid[0]` fires 4 times with 2.0,4.0,6.0,8.0 and `rsp_last` on the 4th; `rsp_valid[1]` stays 0.
- Both requesters post 3-beat packets in cycle 0 after reset → requester 0's 3 beats issue at cycles 1-3, IDLE at 4, requester 1 at 5-7; no interleave; results are routed to consumers 0,0,0,1,1,1.
- `TAG_DEPTH=4` with `rsp_ready` held 0 → exactly 4 issues, then `mult_valid=0` and `busy=1`. Raising `rsp_ready` drains the results and issue resumes.
- Head tag = 1 with `rsp_ready[1]=0` and `rsp_ready[0]=1` → `res_ready=0`; the following result for consumer 0 is not delivered until consumer 1 accepts.
- `res_valid=1` with the FIFO empty → `res_ready=1`, no `rsp_valid`, `err_orphan=1`, which stays 1 for 100 cycles.
- `aresetn` pulsed low mid-packet with 2 beats outstanding → all outputs immediately 0; after release `tag_cnt=0` and the next arbitration starts from requester 0.
